// File: rtl/nwr_stream_gen.sv
// nwr_stream_gen: NWRITE request stream generator for the SRIO logical layer.
// Emits programmed packet bursts with address stepping, gaps and data patterns.
module nwr_stream_gen #(
  parameter int         DATA_W    = 64,
  parameter int         ADDR_W    = 34,
  parameter int         MAX_BYTES = 256,
  parameter int         CNT_W     = 16,
  parameter logic [3:0] FTYPE     = 4'h5,
  parameter logic [3:0] TTYPE     = 4'h4
) (
  input  logic                  log_clk,
  input  logic                  log_rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [CNT_W-1:0]      cfg_pkt_num,
  input  logic [11:0]           cfg_len,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [7:0]            cfg_gap,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_W-1:0]     cfg_seed,
  input  logic                  nwr_ready_in,
  input  logic                  nwr_busy_in,
  input  logic                  user_tready_in,
  output logic [ADDR_W-1:0]     user_addr_o,
  output logic [3:0]            user_ftype_o,
  output logic [3:0]            user_ttype_o,
  output logic [11:0]           user_tsize_o,
  output logic [DATA_W-1:0]     user_tdata_o,
  output logic                  user_tvalid_o,
  output logic [DATA_W/8-1:0]   user_tkeep_o,
  output logic                  user_tlast_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      pkt_cnt_o
);

  localparam int B = DATA_W / 8;
  localparam logic [11:0] BL = 12'(B);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [DATA_W-1:0] D_ONE = 1;
  localparam logic [B-1:0] K_ALL = '1;

  typedef enum logic [1:0] {IDLE, WAIT_RDY, SEND, GAP} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  pkt_num_q, pkt_cnt_q;
  logic [11:0]       len_q, left_q, tsize_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        gap_q, gcnt_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q, g_q, data;
  logic [B-1:0]      keep;
  logic [3:0]        ftype_q, ttype_q;
  logic              odd_q, stop_q, done_q, err_q;

  logic bad_len, start_ok, stop_eff;
  logic xfer, last, last_xfer, run_end;

  assign bad_len   = (cfg_len == 12'd0) ||
                     ({1'b0, cfg_len} > 13'(MAX_BYTES));
  assign start_ok  = cfg_start && !bad_len;
  assign stop_eff  = stop_q || cfg_stop;
  assign xfer      = (state_q == SEND) && user_tready_in;
  assign last      = left_q <= BL;
  assign last_xfer = xfer && last;
  assign run_end   = stop_eff ||
                     ((pkt_num_q != '0) &&
                      ((pkt_cnt_q + CNT_ONE) == pkt_num_q));

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start_ok) state_d = WAIT_RDY;
      WAIT_RDY:
        if (stop_eff) state_d = IDLE;
        else if (nwr_ready_in && !nwr_busy_in) state_d = SEND;
      SEND:
        if (last_xfer) begin
          if (run_end)           state_d = IDLE;
          else if (gap_q == '0)  state_d = WAIT_RDY;
          else                   state_d = GAP;
        end
      GAP:
        if (stop_eff)          state_d = IDLE;
        else if (gcnt_q == '0) state_d = WAIT_RDY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      pkt_num_q <= '0;
      pkt_cnt_q <= '0;
      len_q     <= '0;
      left_q    <= '0;
      tsize_q   <= '0;
      addr_q    <= '0;
      gap_q     <= '0;
      gcnt_q    <= '0;
      mode_q    <= '0;
      seed_q    <= '0;
      g_q       <= '0;
      ftype_q   <= '0;
      ttype_q   <= '0;
      odd_q     <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ftype_q <= FTYPE;
      ttype_q <= TTYPE;
      done_q  <= (state_q != IDLE) && (state_d == IDLE);
      err_q   <= (state_q == IDLE) && cfg_start && bad_len;
      if (state_q == IDLE) stop_q <= 1'b0;
      else if (cfg_stop)   stop_q <= 1'b1;
      if ((state_q == IDLE) && start_ok) begin
        pkt_num_q <= cfg_pkt_num;
        pkt_cnt_q <= '0;
        len_q     <= cfg_len;
        left_q    <= cfg_len;
        tsize_q   <= cfg_len - 12'd1;
        addr_q    <= cfg_addr;
        gap_q     <= cfg_gap;
        mode_q    <= cfg_mode;
        seed_q    <= cfg_seed;
        g_q       <= '0;
        odd_q     <= 1'b0;
      end
      if (xfer) begin
        g_q <= g_q + D_ONE;
        if (last) begin
          left_q    <= len_q;
          odd_q     <= 1'b0;
          pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
          addr_q    <= addr_q + ADDR_W'(len_q);
          gcnt_q    <= gap_q - 8'd1;
        end else begin
          left_q <= left_q - BL;
          odd_q  <= !odd_q;
        end
      end else if (state_q == GAP) begin
        gcnt_q <= gcnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    data = seed_q + g_q;
    unique case (1'b1)
      (mode_q == 2'd1): data = seed_q;
      (mode_q == 2'd2): data = odd_q ? ~seed_q : seed_q;
      default: data = seed_q + g_q;
    endcase
  end

  // Last beat keeps the leading left_q bytes; MSB of tkeep is byte 0.
  assign keep = last ? ~(K_ALL >> left_q) : K_ALL;

  assign user_tvalid_o = (state_q == SEND);
  assign user_tdata_o  = user_tvalid_o ? data : '0;
  assign user_tkeep_o  = user_tvalid_o ? keep : '0;
  assign user_tlast_o  = user_tvalid_o && last;
  assign user_addr_o   = addr_q;
  assign user_tsize_o  = tsize_q;
  assign user_ftype_o  = ftype_q;
  assign user_ttype_o  = ttype_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign pkt_cnt_o     = pkt_cnt_q;

endmodule
